// File: rtl/pe_fx_mac.sv
// pe_fx_mac: fixed-point processing element with a local weight buffer and a bias.
// It runs a dot product of streamed activations against the stored weights,
// with optional ReLU. Commands, input beats and results use valid/ready handshakes.
// Optional build macro PE_SAT_EN: when defined, the result saturates to the
// DATA_W signed range when it is narrowed; otherwise the low DATA_W bits are kept.
module pe_fx_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   ctrl,
  input  logic [$clog2(DEPTH+1)-1:0]   cmd_len,
  input  logic                         do_act,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   wgt_count,
  output logic                         busy
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = 2*DATA_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_BIASLD = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam logic [2:0] OP_LOAD_W = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_BIAS   = 3'd4;

  logic [2:0]               state;
  logic [CNT_W-1:0]         len_q;
  logic [CNT_W-1:0]         ptr_q;
  logic [CNT_W-1:0]         len_eff;
  logic [CNT_W-1:0]         run_len;
  logic                     last_beat;
  logic [DATA_W-1:0]        w_mem [DEPTH];
  logic [DATA_W-1:0]        w_rd;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  bias_acc;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     act_q;
  logic [1:0]               drain_q;
  logic [DATA_W-1:0]        result;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD) || (state == S_BIASLD) || (state == S_MAC);

  assign len_eff   = (cmd_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cmd_len;
  assign run_len   = (len_eff > wgt_count) ? wgt_count : len_eff;
  assign last_beat = ((ptr_q + CNT_W'(1)) == len_q);
  assign w_rd      = w_mem[ptr_q[AW-1:0]];
  assign bias_acc  = ACC_W'(bias_q) <<< FRAC_W;

  // Result shaping: drop fraction bits, optional ReLU, then narrow to DATA_W.
  always_comb begin
    result = acc_q[FRAC_W +: DATA_W];
`ifdef PE_SAT_EN
    // Bits above the kept field must all match the sign, otherwise clamp.
    if (acc_q[ACC_W-1:FRAC_W+DATA_W-1] != {(ACC_W-FRAC_W-DATA_W+1){acc_q[ACC_W-1]}})
      result = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    if (act_q && acc_q[ACC_W-1])
      result = '0;
  end

  // Weight buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && state == S_LOAD && in_valid)
      w_mem[ptr_q[AW-1:0]] <= in_data;
  end

  // Control FSM, two-stage multiply-accumulate pipe and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      ptr_q     <= '0;
      wgt_count <= '0;
      bias_q    <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      prod_vld  <= 1'b0;
      act_q     <= 1'b0;
      drain_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      prod_vld <= 1'b0;
      if (prod_vld)
        acc_q <= acc_q + ACC_W'(prod_q);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (ctrl)
              OP_LOAD_W: begin
                ptr_q <= '0;
                len_q <= len_eff;
                if (len_eff == '0)
                  wgt_count <= '0;
                else
                  state <= S_LOAD;
              end
              OP_BIAS: state <= S_BIASLD;
              OP_CLEAR: begin
                wgt_count <= '0;
                bias_q    <= '0;
              end
              OP_RUN: begin
                ptr_q   <= '0;
                len_q   <= run_len;
                act_q   <= do_act;
                acc_q   <= bias_acc;
                drain_q <= '0;
                state   <= (run_len == '0) ? S_DRAIN : S_MAC;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ptr_q <= ptr_q + CNT_W'(1);
            if (last_beat) begin
              wgt_count <= len_q;
              state     <= S_IDLE;
            end
          end
        end
        S_BIASLD: begin
          if (in_valid) begin
            bias_q <= in_data;
            state  <= S_IDLE;
          end
        end
        S_MAC: begin
          if (in_valid) begin
            prod_q   <= PROD_W'($signed(in_data)) * PROD_W'($signed(w_rd));
            prod_vld <= 1'b1;
            ptr_q    <= ptr_q + CNT_W'(1);
            if (last_beat) begin
              drain_q <= '0;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles let the last product land in acc_q; the third registers the result.
          if (drain_q == 2'd2) begin
            out_data  <= result;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fx_mac.sv
// Self-checking bench for pe_fx_mac: directed scenarios with literal expectations
// plus randomized command/beat traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_pe_fx_mac;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int DEPTH  = 16;
  localparam int CLW    = $clog2(DEPTH+1);
  localparam int TMO    = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [2:0] ctrl = '0;
  logic [CLW-1:0] cmd_len = '0;
  logic do_act = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic cmd_ready, in_ready, out_valid, busy;
  logic [DATA_W-1:0] out_data;
  logic [CLW-1:0] wgt_count;

  int checks = 0;
  int failures = 0;

  pe_fx_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .ctrl(ctrl),
    .cmd_len(cmd_len), .do_act(do_act), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wgt_count(wgt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: wrap the sum to the accumulator width, shift, ReLU, narrow.
  function automatic logic [DATA_W-1:0] fx_result(input longint s, input bit act);
    logic signed [ACC_W-1:0] a;
    longint r;
    longint hi;
    longint lo;
    a  = s[ACC_W-1:0];
    r  = longint'(a) >>> FRAC_W;
    hi = (longint'(1) <<< (DATA_W-1)) - 1;
    lo = -(longint'(1) <<< (DATA_W-1));
    if (act && r < 0) r = 0;
`ifdef PE_SAT_EN
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`else
    if (hi < lo) r = 0;
`endif
    return r[DATA_W-1:0];
  endfunction

  // ---------------- transaction-level model ----------------
  typedef enum {P_NONE, P_LOAD, P_BIAS, P_RUN} pend_t;
  pend_t pend = P_NONE;
  bit m_init = 0, res_pend = 0, just_rst = 0, m_act = 0;
  longint m_w [DEPTH];
  int m_wcnt = 0;
  longint m_bias = 0;
  longint m_sum = 0;
  int need = 0, got = 0;
  logic [DATA_W-1:0] m_res = '0;
  longint ncnt = 0, due = 0;

  // Compare process: checks outputs each cycle, then applies this cycle's handshakes.
  always @(negedge clk) begin
    bit exp_idle, exp_ov;
    int len_e;
    ncnt++;
    exp_idle = (pend == P_NONE) && !res_pend;
    exp_ov   = res_pend && (ncnt >= due);
    if (m_init) begin
      check("cmd_ready", cmd_ready, exp_idle);
      check("busy", busy, !exp_idle);
      check("in_ready", in_ready, pend != P_NONE);
      check("out_valid", out_valid, exp_ov);
      check("wgt_count", wgt_count, m_wcnt);
      if (exp_ov) check("out_data", out_data, m_res);
      if (just_rst) check("out_data_rst", out_data, 0);
    end
    if (rst) begin
      m_init = 1; just_rst = 1; pend = P_NONE; res_pend = 0; m_wcnt = 0; m_bias = 0;
    end else if (m_init) begin
      just_rst = 0;
      if (exp_ov && out_ready) res_pend = 0;
      if (cmd_valid && exp_idle) begin
        len_e = (int'(cmd_len) > DEPTH) ? DEPTH : int'(cmd_len);
        case (ctrl)
          3'd1: begin
            if (len_e == 0) m_wcnt = 0;
            else begin pend = P_LOAD; need = len_e; got = 0; end
          end
          3'd4: pend = P_BIAS;
          3'd3: begin m_wcnt = 0; m_bias = 0; end
          3'd2: begin
            need  = (len_e < m_wcnt) ? len_e : m_wcnt;
            got   = 0;
            m_act = do_act;
            m_sum = m_bias * (longint'(1) <<< FRAC_W);
            if (need == 0) begin
              m_res = fx_result(m_sum, m_act); res_pend = 1; due = ncnt + 4;
            end else pend = P_RUN;
          end
          default: ;
        endcase
      end else if (in_valid && pend != P_NONE) begin
        case (pend)
          P_LOAD: begin
            m_w[got] = longint'($signed(in_data));
            got++;
            if (got == need) begin m_wcnt = need; pend = P_NONE; end
          end
          P_BIAS: begin m_bias = longint'($signed(in_data)); pend = P_NONE; end
          P_RUN: begin
            m_sum += longint'($signed(in_data)) * m_w[got];
            got++;
            if (got == need) begin
              pend = P_NONE; m_res = fx_result(m_sum, m_act); res_pend = 1; due = ncnt + 4;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input int len, input bit act);
    int t = 0;
    ctrl = op; cmd_len = CLW'(len); do_act = act; cmd_valid = 1'b1;
    while (!cmd_ready && t < TMO) begin tick(); t++; end
    check("cmd_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; ctrl = '0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input int max_gap);
    int t = 0;
    in_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) tick();
    in_valid = 1'b1; in_data = d;
    while (!in_ready && t < TMO) begin tick(); t++; end
    check("beat_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_result(input bit pin, input logic [DATA_W-1:0] lit, input int hold,
                            output int lat);
    int t = 0;
    out_ready = 1'b0;
    while (!out_valid && t < TMO) begin tick(); t++; end
    lat = t;
    check("result_wait", out_valid, 1);
    if (pin) begin
      check("pin_dut", out_data, lit);
      check("pin_model", m_res, lit);
    end
    repeat (hold) tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t, len, n, op;
    logic [DATA_W-1:0] sat_exp;
`ifdef PE_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h0100;
`endif
    rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_wgt_count", wgt_count, 0);

    // Basic dot product with bias, latency pinned
    do_cmd(3'd1, 3, 0);
    send_beat(16'h0100, 1); send_beat(16'h0200, 1); send_beat(16'hFF00, 1);
    check("wgt_count_3", wgt_count, 3);
    do_cmd(3'd4, 0, 0); send_beat(16'h0080, 1);
    do_cmd(3'd2, 3, 0);
    send_beat(16'h0100, 2); send_beat(16'h0100, 2); send_beat(16'h0300, 2);
    get_result(1, 16'h0080, 0, lat);
    check("latency", lat, 3);

    // Negative result, with and without ReLU
    do_cmd(3'd2, 3, 0);
    send_beat(16'h0000, 0); send_beat(16'h0000, 0); send_beat(16'h0400, 0);
    get_result(1, 16'hFC80, 1, lat);
    do_cmd(3'd2, 3, 1);
    send_beat(16'h0000, 1); send_beat(16'h0000, 1); send_beat(16'h0400, 1);
    get_result(1, 16'h0000, 0, lat);

    // RUN longer than wgt_count: only three beats taken
    do_cmd(3'd2, 5, 0);
    send_beat(16'h0100, 1); send_beat(16'h0100, 1); send_beat(16'h0300, 1);
    in_valid = 1'b1; in_data = 16'h7FFF;
    check("extra_beat_blocked", in_ready, 0);
    get_result(1, 16'h0080, 2, lat);
    in_valid = 1'b0;

    // CLEAR then RUN: result equals the cleared bias, latency from command
    do_cmd(3'd3, 0, 0);
    check("clear_wgt_count", wgt_count, 0);
    do_cmd(3'd2, 3, 0);
    get_result(1, 16'h0000, 0, lat);
    check("latency_len0", lat, 3);

    // Large product: saturate or wrap
    do_cmd(3'd1, 1, 0); send_beat(16'h7F00, 0);
    do_cmd(3'd2, 1, 0); send_beat(16'h7F00, 0);
    get_result(1, sat_exp, 0, lat);

    // Back-pressure: out_ready low 10 cycles, command attempt rejected
    do_cmd(3'd2, 1, 0); send_beat(16'h0100, 0);
    t = 0;
    while (!out_valid && t < TMO) begin tick(); t++; end
    ctrl = 3'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, 16'h7F00);
      check("hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0; ctrl = '0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("clear_rejected", wgt_count, 1);

    // Reset in the middle of a RUN
    do_cmd(3'd1, 3, 0);
    send_beat(16'h0100, 0); send_beat(16'h0200, 0); send_beat(16'hFF00, 0);
    do_cmd(3'd2, 3, 0); send_beat(16'h0100, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_wgt_count", wgt_count, 0);
    tick();
    do_cmd(3'd1, 3, 0);
    send_beat(16'h0100, 1); send_beat(16'h0200, 1); send_beat(16'hFF00, 1);
    do_cmd(3'd2, 3, 0);
    send_beat(16'h0200, 1); send_beat(16'h0100, 1); send_beat(16'h0100, 1);
    get_result(1, 16'h0300, 0, lat);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(5, 0);
      if ($urandom_range(3, 0) == 0) begin
        in_valid = 1'b1; in_data = DATA_W'($urandom); tick(); in_valid = 1'b0;
      end
      case (op)
        0: begin
          len = $urandom_range(DEPTH+3, 0);
          do_cmd(3'd1, len, 0);
          n = (len > DEPTH) ? DEPTH : len;
          for (int j = 0; j < n; j++) send_beat(DATA_W'($urandom), 2);
        end
        1: begin
          do_cmd(3'd4, 0, 0);
          send_beat(DATA_W'($urandom), 2);
        end
        2, 3: begin
          len = $urandom_range(DEPTH+3, 0);
          n = (len > DEPTH) ? DEPTH : len;
          if (n > m_wcnt) n = m_wcnt;
          do_cmd(3'd2, len, 1'($urandom_range(1, 0)));
          for (int j = 0; j < n; j++) send_beat(DATA_W'($urandom), 2);
          get_result(0, '0, $urandom_range(3, 0), lat);
        end
        4: do_cmd(3'd3, 0, 0);
        default: do_cmd(3'd0, $urandom_range(DEPTH, 0), 0);
      endcase
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
